// File: rtl/lift_pkg.sv
// Shared definitions for the RNS lift result writeback stage.
package lift_pkg;

    localparam int unsigned COEFF_W   = 30;
    localparam logic [2:0]  RSD_SMALL = 3'd7;
    localparam logic [2:0]  RSD_BIG   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_t;

    function automatic logic [2:0] rsd_count(input logic mode);
        return mode ? RSD_BIG : RSD_SMALL;
    endfunction

endpackage

// File: rtl/lift_wb_bank.sv
// Two-bank ping-pong residue buffer: fill side, full flags and drain-side read port.
module lift_wb_bank #(
    parameter int unsigned COEFF_W = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [2:0]         rsd_cnt,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               rd_done,
    input  logic               rd_next,
    input  logic [2:0]         rd_idx,
    output logic [COEFF_W-1:0] rd_data,
    output logic               drain_full,
    output logic               next_full,
    output logic               wr_drop
);

    logic [COEFF_W-1:0] mem [2][8];
    logic [1:0]         full;
    logic               fill_ptr;
    logic               drain_ptr;
    logic [2:0]         fill_cnt;
    logic               addr_ok;
    logic               fill_free;
    logic               wr_acc;
    logic               fill_done;

    // A bank whose last entry is being drained this cycle may already accept new residues.
    always_comb begin
        addr_ok    = wr_addr < rsd_cnt;
        fill_free  = !full[fill_ptr] || (rd_done && (drain_ptr == fill_ptr));
        wr_acc     = wr_en && addr_ok && fill_free;
        wr_drop    = wr_en && addr_ok && !fill_free;
        fill_done  = wr_acc && ((fill_cnt + 3'd1) == rsd_cnt);
        rd_data    = mem[drain_ptr ^ rd_next][rd_idx];
        drain_full = full[drain_ptr];
        next_full  = full[~drain_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full      <= '0;
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            fill_cnt  <= '0;
        end else begin
            if (rd_done) begin
                full[drain_ptr] <= 1'b0;
                drain_ptr       <= ~drain_ptr;
            end
            if (wr_acc) begin
                if (fill_done) begin
                    full[fill_ptr] <= 1'b1;
                    fill_ptr       <= ~fill_ptr;
                    fill_cnt       <= '0;
                end else begin
                    fill_cnt <= fill_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[fill_ptr][wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/lift_result_writeback.sv
// Gathers lift-core residues per coefficient and drains them to residue memory.
// Optional LIFT_WB_OVERFLOW_CHECK_EN builds the sticky overflow flag for dropped writes.
module lift_result_writeback #(
    parameter int unsigned COEFF_W = 30,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned N_COEFF = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               start,
    input  logic               in_we,
    input  logic [2:0]         in_addr,
    input  logic [COEFF_W-1:0] in_data,
    output logic               out_we,
    input  logic               out_ready,
    output logic [2:0]         out_rsd,
    output logic [ADDR_W-1:0]  out_coeff_addr,
    output logic [COEFF_W-1:0] out_data,
    output logic               done,
    output logic               overflow
);

    import lift_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFF - 1);

    drain_state_t       state;
    logic               mode_q;
    logic [2:0]         rsd_cnt;
    logic               xfer;
    logic               last_rsd;
    logic               rd_done;
    logic [2:0]         rd_idx;
    logic               wr_en;
    logic [COEFF_W-1:0] rd_data;
    logic               drain_full;
    logic               next_full;
    logic               wr_drop;

    // Read index looks one entry ahead so out_data is registered with its index.
    always_comb begin
        rsd_cnt  = rsd_count(mode_q);
        xfer     = (state == ST_DRAIN) && out_we && out_ready;
        last_rsd = out_rsd == (rsd_cnt - 3'd1);
        rd_done  = xfer && last_rsd;
        rd_idx   = '0;
        if (xfer && !last_rsd) begin
            rd_idx = out_rsd + 3'd1;
        end
        wr_en = in_we && (state != ST_DONE) && !start;
    end

    lift_wb_bank #(
        .COEFF_W(COEFF_W)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .rsd_cnt    (rsd_cnt),
        .wr_en      (wr_en),
        .wr_addr    (in_addr),
        .wr_data    (in_data),
        .rd_done    (rd_done),
        .rd_next    (rd_done),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .drain_full (drain_full),
        .next_full  (next_full),
        .wr_drop    (wr_drop)
    );

    always_ff @(posedge clk) begin
        if (rst || start) begin
            state          <= ST_IDLE;
            mode_q         <= rst ? 1'b0 : mode;
            out_we         <= 1'b0;
            out_rsd        <= '0;
            out_coeff_addr <= '0;
            out_data       <= '0;
            done           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (drain_full) begin
                        state    <= ST_DRAIN;
                        out_we   <= 1'b1;
                        out_rsd  <= '0;
                        out_data <= rd_data;
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        if (last_rsd) begin
                            out_coeff_addr <= out_coeff_addr + 1'b1;
                            if (out_coeff_addr == LAST_ADDR) begin
                                state  <= ST_DONE;
                                out_we <= 1'b0;
                                done   <= 1'b1;
                            end else if (next_full) begin
                                out_rsd  <= '0;
                                out_data <= rd_data;
                            end else begin
                                state  <= ST_IDLE;
                                out_we <= 1'b0;
                            end
                        end else begin
                            out_rsd  <= out_rsd + 3'd1;
                            out_data <= rd_data;
                        end
                    end
                end
                ST_DONE: begin
                    out_we <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    out_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef LIFT_WB_OVERFLOW_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = wr_drop;
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_lift_result_writeback.sv
// Self-checking bench for lift_result_writeback: vector table plus scoreboard of drained writes.
module tb_lift_result_writeback;

    localparam int unsigned CW = 30;
    localparam int unsigned AW = 12;
    localparam int unsigned NC = 4;
`ifdef LIFT_WB_OVERFLOW_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          start;
    logic          in_we;
    logic [2:0]    in_addr;
    logic [CW-1:0] in_data;
    logic          out_we;
    logic          out_ready;
    logic [2:0]    out_rsd;
    logic [AW-1:0] out_coeff_addr;
    logic [CW-1:0] out_data;
    logic          done;
    logic          overflow;

    lift_result_writeback #(
        .COEFF_W(CW),
        .ADDR_W (AW),
        .N_COEFF(NC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .start         (start),
        .in_we         (in_we),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .out_we        (out_we),
        .out_ready     (out_ready),
        .out_rsd       (out_rsd),
        .out_coeff_addr(out_coeff_addr),
        .out_data      (out_data),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] coeff;
        logic [2:0]    rsd;
        logic [CW-1:0] data;
    } exp_t;

    typedef struct {
        logic [2:0]    addr;
        logic [CW-1:0] data;
        bit            accept;
    } vec_t;

    int            n_vec  = 0;
    int            n_err  = 0;
    int            n_xfer = 0;
    exp_t          sb[$];
    vec_t          tbl[28];
    int            mdl_r = 7;
    int            mdl_cnt = 0;
    int            mdl_coeff = 0;
    logic [CW-1:0] mdl_mem[8];

    logic          hold_v = 1'b0;
    logic [2:0]    hold_rsd;
    logic [AW-1:0] hold_addr;
    logic [CW-1:0] hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset(input logic m);
        mdl_r     = m ? 6 : 7;
        mdl_cnt   = 0;
        mdl_coeff = 0;
        sb.delete();
        n_xfer    = 0;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'b0;
        model_reset(m);
    endtask

    task automatic wr(input logic [2:0] a, input logic [CW-1:0] d, input bit accept);
        exp_t e;
        in_we   = 1'b1;
        in_addr = a;
        in_data = d;
        if (accept && (int'(a) < mdl_r)) begin
            mdl_mem[a] = d;
            mdl_cnt++;
            if (mdl_cnt == mdl_r) begin
                for (int r = 0; r < mdl_r; r++) begin
                    e.coeff = AW'(mdl_coeff);
                    e.rsd   = 3'(r);
                    e.data  = mdl_mem[r];
                    sb.push_back(e);
                end
                mdl_coeff++;
                mdl_cnt = 0;
            end
        end
        @(posedge clk); #1;
        in_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input string name, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
        check(name, 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int k = 0; k < budget && !done; k++) @(negedge clk);
        check(name, 64'(done), 64'd1);
        @(posedge clk); #1;
    endtask

    // Monitor: scoreboard pops on each handshake, stall cycles must hold the bus.
    always @(negedge clk) begin
        exp_t e;
        if (rst || start) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_we", 64'(out_we), 64'd1);
                check("hold_bus", 64'({out_rsd, out_coeff_addr, out_data}),
                      64'({hold_rsd, hold_addr, hold_data}));
            end
            hold_v = out_we && !out_ready;
            if (hold_v) begin
                hold_rsd  = out_rsd;
                hold_addr = out_coeff_addr;
                hold_data = out_data;
            end
            if (out_we && out_ready) begin
                n_xfer++;
                check("xfer_expected", 64'(sb.size() == 0), 64'd0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("xfer", 64'({out_coeff_addr, out_rsd, out_data}),
                          64'({e.coeff, e.rsd, e.data}));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_we = 1'b0;
        in_addr = '0; in_data = '0; out_ready = 1'b1;
        for (int i = 0; i < 28; i++) begin
            tbl[i].addr   = 3'(i % 7);
            tbl[i].data   = CW'(100 * (i / 7) + i % 7);
            tbl[i].accept = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_we", 64'(out_we), 64'd0);
        check("rst_out_rsd", 64'(out_rsd), 64'd0);
        check("rst_coeff_addr", 64'(out_coeff_addr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        // Mode 0 full polynomial, back-to-back draining
        do_start(1'b0);
        for (int i = 0; i < 28; i++) wr(tbl[i].addr, tbl[i].data, tbl[i].accept);
        wait_done("m0_done", 60);
        check("m0_xfers", 64'(n_xfer), 64'd28);
        check("m0_sb_empty", 64'(sb.size()), 64'd0);
        check("m0_overflow", 64'(overflow), 64'd0);
        check("m0_final_addr", 64'(out_coeff_addr), 64'd4);
        wr(3'd0, CW'(5), 1'b0);
        idle(3);
        check("done_ignores_we", 64'(out_we), 64'd0);
        check("done_level", 64'(done), 64'd1);

        // Mode 1, reversed residue order, first-write latency
        do_start(1'b1);
        check("start_clears_done", 64'(done), 64'd0);
        for (int r = 5; r >= 1; r--) wr(3'(r), CW'(200 + r), 1'b1);
        wr(3'd0, CW'(200), 1'b1);
        check("lat_e_we", 64'(out_we), 64'd0);
        @(posedge clk); #1;
        check("lat_e1_we", 64'(out_we), 64'd1);
        check("lat_e1_rsd", 64'(out_rsd), 64'd0);
        check("lat_e1_data", 64'(out_data), 64'd200);
        wait_drained("m1_drain", 20);
        idle(2);
        check("m1_xfers", 64'(n_xfer), 64'd6);
        check("m1_addr", 64'(out_coeff_addr), 64'd1);
        check("m1_idle_we", 64'(out_we), 64'd0);

        // Mode 1, out-of-range residue index is ignored
        do_start(1'b1);
        for (int r = 0; r < 5; r++) wr(3'(r), CW'(300 + r), 1'b1);
        wr(3'd7, CW'(999), 1'b1);
        idle(4);
        check("addr7_no_drain", 64'(out_we), 64'd0);
        wr(3'd5, CW'(305), 1'b1);
        wait_drained("addr7_drain", 20);
        idle(2);
        check("addr7_xfers", 64'(n_xfer), 64'd6);

        // Stalled memory while the lift keeps writing
        do_start(1'b0);
        out_ready = 1'b0;
        for (int r = 0; r < 7; r++) wr(3'(r), CW'(400 + r), 1'b1);
        for (int r = 0; r < 7; r++) wr(3'(r), CW'(500 + r), 1'b1);
        wr(3'd0, CW'(600), 1'b0);
        idle(3);
        check("stall_overflow", 64'(overflow), 64'(OVF_EXP));
        check("stall_no_xfer", 64'(n_xfer), 64'd0);
        out_ready = 1'b1;
        wait_drained("stall_drain", 40);
        for (int r = 0; r < 7; r++) wr(3'(r), CW'(700 + r), 1'b1);
        for (int r = 0; r < 7; r++) wr(3'(r), CW'(800 + r), 1'b1);
        wait_done("stall_done", 40);
        check("stall_xfers", 64'(n_xfer), 64'd28);
        check("stall_overflow_kept", 64'(overflow), 64'(OVF_EXP));

        // Abort mid-drain of coefficient 2, then a clean run
        do_start(1'b0);
        check("start_clears_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 21; i++) wr(tbl[i].addr, tbl[i].data + CW'(900), 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = out_we && (out_coeff_addr == AW'(2));
        end
        check("abort_reached", 64'(found), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_reset(1'b0);
        check("abort_we", 64'(out_we), 64'd0);
        check("abort_addr", 64'(out_coeff_addr), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        idle(3);
        check("abort_stays_idle", 64'(out_we), 64'd0);
        for (int i = 0; i < 28; i++) wr(tbl[i].addr, tbl[i].data + CW'(50), 1'b1);
        wait_done("rerun_done", 60);
        check("rerun_xfers", 64'(n_xfer), 64'd28);
        check("rerun_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lift_result_writeback.md
# lift_result_writeback

Downstream stage of the RNS lift datapath. Consumes the per-residue write stream (data, residue index, write enable) produced by the lift core, one coefficient at a time. Gathers each coefficient's residues into a two-bank ping-pong buffer and drains complete coefficients to the residue-memory write port, tagging each write with residue index and coefficient address. Signals completion after a full polynomial of `N_COEFF` coefficients.

## Interface
Parameters:
- `COEFF_W`, 30 — residue width.
- `ADDR_W`, 12 — coefficient address width.
- `N_COEFF`, 4096 — coefficients per polynomial.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `mode`  in  1  — 0 = small lift, 7 output residues/coeff; 1 = big lift, 6 output residues/coeff. Sampled only at `start`.
- `start`  in  1  — one-cycle pulse; flushes banks, clears counters and flags, latches `mode`.
- `in_we`  in  1  — residue write strobe from the lift core.
- `in_addr`  in  3  — residue index.
- `in_data`  in  COEFF_W  — residue value.
- `out_we`  out  1  — write valid toward residue memory.
- `out_ready`  in  1  — memory accepts; a transfer happens when `out_we && out_ready`.
- `out_rsd`  out  3  — residue index of the current write.
- `out_coeff_addr`  out  ADDR_W  — coefficient address of the current write.
- `out_data`  out  COEFF_W  — residue value.
- `done`  out  1  — level; high once `N_COEFF` coefficients are drained, until `start`/`rst`.
- `overflow`  out  1  — sticky error flag (see Configuration).

## Operation
- Expected count R = 7 when latched mode = 0, R = 6 when latched mode = 1.
- Fill side:
  - `in_we` writes `in_data` into the fill bank at `in_addr` and increments the fill count.
  - `in_addr >= R` is ignored and not counted.
  - When the fill count reaches R, the bank is marked full, the fill pointer toggles, and the count clears.
- Drain FSM states: IDLE, DRAIN, DONE.
  - IDLE -> DRAIN when the drain bank is full.
  - DRAIN presents entries 0..R-1 in order, advancing on each transfer.
  - After entry R-1 transfers: clear that bank's full flag, toggle the drain pointer, and increment `out_coeff_addr`.
  - Next state: DONE if `out_coeff_addr` was `N_COEFF-1`; else DRAIN if the other bank is already full (back-to-back, no bubble); else IDLE.
- DONE: `done` = 1 and `in_we` is ignored. `start` returns the FSM to IDLE.
- Hold rule: while `out_we=1 && out_ready=0`, `out_rsd`, `out_coeff_addr` and `out_data` stay stable.
- Both banks full and `in_we` high: the write is dropped.
- A fill completing in the same cycle as the drain of the other bank finishing: both actions take effect and no data is lost.
- `start` or `rst` mid-operation aborts any drain and discards bank contents. `out_we` is low the next cycle.
- Reset values: `out_we`=0, `out_rsd`=0, `out_coeff_addr`=0, `out_data`=0, `done`=0, `overflow`=0; both banks empty, pointers at bank 0, latched mode = 0.

## Timing
- All outputs are registered.
- The completing `in_we` is sampled at edge E and sets the full flag at E. The first `out_we` is high after edge E+1, so it is visible two cycles after the completing write cycle.
- Drain throughput is one residue per cycle while `out_ready` is high.
- `done` rises on the edge that accepts the final transfer.

## Configuration
- `LIFT_WB_OVERFLOW_CHECK_EN` defined: `overflow` sets when `in_we` is dropped because both banks are full. It stays set until `start`/`rst`.
- Undefined: the overflow logic is not built, `overflow` is tied to 0, and dropped writes go unreported.

## Structure
- Shared package `lift_pkg`:
  - `COEFF_W`.
  - `RSD_SMALL` = 7, `RSD_BIG` = 6.
  - Drain-state enum.
- Sub-module `lift_wb_bank`: 2 × 8 × `COEFF_W` register file with per-bank full flags, fill/drain pointers and fill counter. The FSM and address counter stay in the top.

## Test plan
- Mode 0, `N_COEFF`=4, `out_ready`=1, 28 writes with `in_data` = 100·coeff + rsd -> 28 `out_we` with matching (coeff, rsd, data); `done`=1 after the last; `overflow`=0.
- Mode 1, residues written in order 5,4,3,2,1,0 -> drained in order 0..5 with correct data; the sixth write triggers `out_we` two cycles later.
- `out_ready` low for 10 cycles mid-drain while the lift keeps writing -> outputs held stable; with the macro defined, the 15th extra write (third coefficient) is dropped and `overflow`=1.
- `in_addr`=7 in mode 1 -> write ignored; the coefficient completes only after six valid writes.
- `start` pulsed while draining coefficient 2 -> `out_we`=0 next cycle, `out_coeff_addr`=0, `done`=0; a fresh run then completes normally.
